// File: rtl/iob_rom_burst_reader_if.sv
// Bundles the burst command, ROM read port and output stream of iob_rom_burst_reader.
// The master modport is the reader, and the slave modport is its environment.
interface iob_rom_burst_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o;
  logic              done_o;
  logic              r_en_o;
  logic [ADDR_W-1:0] r_addr_o;
  logic              r_ready_i;
  logic [DATA_W-1:0] r_data_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport master (
    input  start_i, base_addr_i, len_i, r_ready_i, r_data_i, ready_i,
    output busy_o, done_o, r_en_o, r_addr_o, data_o, valid_o
  );

  modport slave (
    output start_i, base_addr_i, len_i, r_ready_i, r_data_i, ready_i,
    input  busy_o, done_o, r_en_o, r_addr_o, data_o, valid_o
  );
endinterface

// File: rtl/iob_rom_burst_reader.sv
// Walks a contiguous ROM address range and issues one read per word, tolerating request stalls.
// Each word is captured the cycle after it is accepted and streamed out through a 3-entry FIFO.
module iob_rom_burst_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input logic                    clk_i,
  input logic                    arst_i,
  iob_rom_burst_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fifo_q [3];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic       r_en;
  logic       accept;
  logic       push;
  logic       pop;
  logic [2:0] credit_used;

  // A slot is reserved for every in-flight word, so the push that follows an acceptance never overflows.
  assign credit_used = {2'b00, inflight_q} + {1'b0, count_q};
  assign r_en        = (state_q == READ) && (credit_used < 3'd3);
  assign accept      = r_en && bus.r_ready_i;
  assign push        = inflight_q;
  assign pop         = (count_q != 2'd0) && bus.ready_i;

  // NOTE: each combinational output is given a default first, so that no path leaves it unassigned and infers a latch.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
    if (push) wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    inflight_d = accept;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.len_i != '0) begin
            addr_d  = bus.base_addr_i;
            rem_d   = bus.len_i;
            state_d = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Finish as the last word leaves, so done follows the final transfer by one cycle.
        if (!inflight_q && count_d == 2'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: the FIFO storage is reset because data_o shows the head entry directly and must read 0 out of reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= bus.r_data_i;
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.r_en_o   = r_en;
  assign bus.r_addr_o = addr_q;
  assign bus.data_o   = fifo_q[rd_ptr_q];
  assign bus.valid_o  = (count_q != 2'd0);

endmodule

// File: tb/tb_iob_rom_burst_reader.sv
// Directed bench for iob_rom_burst_reader with a ROM model holding mem[a] = 3*a.
// The ROM output is scrambled every cycle that has no acceptance, so a mistimed capture shows up in the data.
module tb_iob_rom_burst_reader;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  iob_rom_burst_reader_if #(.DATA_W(32), .ADDR_W(10), .LEN_W(11)) bus ();
  iob_rom_burst_reader_if #(.DATA_W(32), .ADDR_W(4),  .LEN_W(11)) bus4 ();

  iob_rom_burst_reader #(.DATA_W(32), .ADDR_W(10), .LEN_W(11)) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  iob_rom_burst_reader #(.DATA_W(32), .ADDR_W(4), .LEN_W(11)) dut4 (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus4)
  );

  logic [31:0] rom_q, rom4_q;
  assign bus.r_data_i  = rom_q;
  assign bus4.r_data_i = rom4_q;

  always @(posedge clk) begin
    if (bus.r_en_o && bus.r_ready_i) rom_q <= 32'd3 * 32'(bus.r_addr_o);
    else                             rom_q <= $urandom;
    if (bus4.r_en_o && bus4.r_ready_i) rom4_q <= 32'd3 * 32'(bus4.r_addr_o);
    else                               rom4_q <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy_o),   32'd0);
    check({tag, "_done"},  32'(bus.done_o),   32'd0);
    check({tag, "_ren"},   32'(bus.r_en_o),   32'd0);
    check({tag, "_raddr"}, 32'(bus.r_addr_o), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid_o),  32'd0);
    check({tag, "_data"},  bus.data_o,        32'd0);
  endtask

  // Runs one burst on the 10-bit instance. Cycle c = 0 is the first cycle after start is sampled.
  // r_ready_i is low for c in [stall_at, stall_at+stall_n) and ready_i is low for c in [bp_at, bp_at+bp_n).
  task automatic run_burst(input logic [9:0] base, input int len,
                           input int stall_at, input int stall_n,
                           input int bp_at, input int bp_n,
                           output int first_c, output int last_c);
    int   acc = 0;
    int   idx = 0;
    bit   pending = 0;
    bit   finished = 0;
    logic [9:0] exp_a;
    first_c = -1;
    last_c  = -1;
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.len_i       = 11'(len);
    step();
    bus.start_i = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) step();
      bus.r_ready_i = !(c >= stall_at && c < stall_at + stall_n);
      bus.ready_i   = !(c >= bp_at && c < bp_at + bp_n);
      if (pending) check("req_hold", 32'(bus.r_en_o), 32'd1);
      if (bus.r_en_o) begin
        exp_a = base + 10'(acc);
        check("r_addr", 32'(bus.r_addr_o), 32'(exp_a));
      end
      if (bp_n > 0 && c == bp_at + bp_n - 1) begin
        check("bp_ren_low", 32'(bus.r_en_o), 32'd0);
        check("bp_occupancy", 32'(acc - idx), 32'd3);
      end
      if (bus.r_en_o && bus.r_ready_i) acc++;
      pending = bus.r_en_o && !bus.r_ready_i;
      if (bus.valid_o && bus.ready_i) begin
        exp_a = base + 10'(idx);
        check("data", bus.data_o, 32'd3 * 32'(exp_a));
        if (first_c < 0) first_c = c;
        last_c = c;
        idx++;
      end
      if (bus.done_o) begin
        finished = 1;
        check("done_busy", 32'(bus.busy_o), 32'd0);
        check("done_words", 32'(idx), 32'(len));
        check("done_accepts", 32'(acc), 32'(len));
        check("done_timing", 32'(c), (len == 0) ? 32'd0 : 32'(last_c + 1));
        break;
      end
    end
    check("done_seen", 32'(finished), 32'd1);
    bus.r_ready_i = 1'b1;
    bus.ready_i   = 1'b1;
    step();
    check("done_pulse", 32'(bus.done_o), 32'd0);
    check("idle_busy", 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    int first_c, last_c;
    int n4, acc4;
    bit d4;
    logic [3:0] ea;

    bus.start_i = 1'b0;  bus.base_addr_i = '0;  bus.len_i = '0;
    bus.r_ready_i = 1'b1; bus.ready_i = 1'b1;
    bus4.start_i = 1'b0; bus4.base_addr_i = '0; bus4.len_i = '0;
    bus4.r_ready_i = 1'b1; bus4.ready_i = 1'b1;

    #12;
    check_idle_outputs("reset");
    step();
    arst = 1'b0;
    step();

    // Streaming burst with no stalls: four words on consecutive cycles.
    run_burst(10'h010, 4, 0, 0, 0, 0, first_c, last_c);
    check("t1_latency", 32'(first_c), 32'd2);
    check("t1_consecutive", 32'(last_c - first_c), 32'd3);

    // Zero-length burst.
    run_burst(10'h020, 0, 0, 0, 0, 0, first_c, last_c);
    check("t2_no_data", 32'(first_c), 32'hffffffff);

    // Request stall mid-burst.
    run_burst(10'h100, 8, 2, 5, 0, 0, first_c, last_c);

    // Output backpressure fills the FIFO.
    run_burst(10'h3f8, 16, 0, 0, 3, 10, first_c, last_c);

    // Address wrap on the 4-bit instance.
    bus4.start_i = 1'b1; bus4.base_addr_i = 4'hE; bus4.len_i = 11'd4;
    step();
    bus4.start_i = 1'b0;
    n4 = 0; acc4 = 0; d4 = 0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) step();
      if (bus4.r_en_o && bus4.r_ready_i) begin
        ea = 4'hE + 4'(acc4);
        check("wrap_addr", 32'(bus4.r_addr_o), 32'(ea));
        acc4++;
      end
      if (bus4.valid_o && bus4.ready_i) begin
        ea = 4'hE + 4'(n4);
        check("wrap_data", bus4.data_o, 32'd3 * 32'(ea));
        n4++;
      end
      if (bus4.done_o) begin
        d4 = 1;
        break;
      end
    end
    check("wrap_done", 32'(d4), 32'd1);
    check("wrap_words", 32'(n4), 32'd4);
    step();

    // Asynchronous reset during a burst, then a fresh burst.
    bus.start_i = 1'b1; bus.base_addr_i = 10'h040; bus.len_i = 11'd8;
    step();
    bus.start_i = 1'b0;
    step();
    step();
    check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    arst = 1'b1;
    #1;
    check_idle_outputs("arst");
    step();
    arst = 1'b0;
    step();
    check_idle_outputs("post_arst");
    run_burst(10'h000, 2, 0, 0, 0, 0, first_c, last_c);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
